mult_share_arbiter: RTL and testbench
=====================================

Name: mult_share_arbiter

Overview:
Shares one clocked unsigned multiplier (WIDTH x WIDTH -> 2*WIDTH, fixed latency MULT_LAT) between N_REQ requesters. Requesters issue operand pairs over valid/ready; the block grants round-robin, drives the shared multiplier, tracks each in-flight operation by requester ID, and returns each product to its originator. It sits between the switch/button front-end logic and the multiplier in the FPGA top level.

Parameters:
N_REQ, 2, number of requesters (2..4)
WIDTH, 8, operand width; product is 2*WIDTH
MULT_LAT, 2, cycles from registered operands at the multiplier to a valid product on mul_z (0..4)

Ports:
clk  in  1  system clock
resetn  in  1  reset; one clock; reset is asynchronous and active-low
req_valid  in  N_REQ  operand pair valid, one bit per requester
req_ready  out  N_REQ  grant/accept, one-hot or zero
req_x  in  N_REQ*WIDTH  operand x, requester i at [i*WIDTH +: WIDTH]
req_y  in  N_REQ*WIDTH  operand y, same packing
rsp_valid  out  N_REQ  one-cycle product pulse per requester
rsp_z  out  N_REQ*2*WIDTH  product hold registers, requester i at [i*2*WIDTH +: 2*WIDTH]
mul_x  out  WIDTH  operand x to shared multiplier (registered)
mul_y  out  WIDTH  operand y to shared multiplier (registered)
mul_z  in  2*WIDTH  product from shared multiplier

Behaviour:
- Reset (async, resetn=0): mul_x=0, mul_y=0, rsp_valid=0, rsp_z=0, rr_ptr=0, all tag-pipe valid bits=0. req_ready=0 while resetn=0.
- Arbitration (combinational, per cycle): winner = first i with req_valid[i]=1 searching rr_ptr, rr_ptr+1, ... mod N_REQ. req_ready[winner]=1, all others 0. No valid -> req_ready=0. req_ready never asserted for a requester with req_valid=0.
- Issue: at the edge ending a cycle with a grant: mul_x<=winner's x, mul_y<=winner's y, tag stage 0 <= {valid=1, id=winner}, rr_ptr <= (winner+1) mod N_REQ. No grant: tag stage 0 valid=0, mul_x/mul_y hold, rr_ptr holds.
- Tag pipe: MULT_LAT stages of {valid, id}, shift every cycle, no stall. MULT_LAT=0: stage 0 feeds capture directly.
- Capture: when the last tag stage is valid, rsp_z[id] <= mul_z and rsp_valid[id] is high for exactly the next cycle. Other rsp_z slots hold.
- Latency: request accepted in cycle T -> rsp_valid[id]=1 in cycle T+MULT_LAT+1 with rsp_z[id]=x*y. Throughput: one operation per cycle total.
- Ordering: responses per requester arrive in acceptance order; at most one rsp_valid bit set per cycle.
- No response backpressure: requester must take rsp_z on the rsp_valid pulse; rsp_z holds until the same requester's next capture.
- Arithmetic: unsigned, full 2*WIDTH product; no truncation.
- Requester dropping req_valid without a grant: legal, nothing issued. Operands sampled only in the granted cycle.
- Reset mid-operation: in-flight operations discarded, no rsp_valid after reset release for them; arbitration restarts at requester 0.

Decomposition:
- Package mult_arb_pkg: ID_W = clog2(N_REQ) helper, tag struct {valid, id}, default WIDTH/MULT_LAT constants.
- Sub-module rr_arbiter (N_REQ): req vector + rr_ptr in -> one-hot grant + winner index out, purely combinational; pointer register lives in the parent.

Test Plan:
- Single request: req 0, x=3, y=5 accepted in cycle T -> rsp_valid[0] in T+3 only, rsp_z[0]=15, req_ready[1] never 1.
- Contention: both valid every cycle, req0 x=2,y=7, req1 x=4,y=9 -> grants 0,1,0,1...; alternating rsp_valid with 14 and 36; one op per cycle.
- Corners: 255*255 -> 0xFE01; 0*200 -> 0x0000; 1*255 -> 0x00FF.
- Back-to-back one requester: req 1 sends (1,1),(2,2),(3,3) in consecutive cycles -> rsp_valid[1] three consecutive cycles, rsp_z[1]=1,4,9 in order.
- Reset mid-flight: two ops accepted, resetn low for 1 cycle before capture -> no rsp_valid afterward, rsp_z=0, next contention grants requester 0 first.
- Idle/ready rule: random req_valid patterns -> req_ready always one-hot-or-zero and subset of req_valid; all products match reference model.

Source files
------------

// File: rtl/mult_arb_pkg.sv
// Shared types and defaults for the multiplier-sharing arbiter.
// Tags carry the requester id alongside each operation in flight through the multiplier.
package mult_arb_pkg;

    localparam int DEF_N_REQ    = 2;
    localparam int DEF_WIDTH    = 8;
    localparam int DEF_MULT_LAT = 2;
    localparam int MAX_ID_W     = 2;

    // At least one bit so a two-requester build still has a usable index.
    function automatic int id_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    typedef struct packed {
        logic                valid;
        logic [MAX_ID_W-1:0] id;
    } tag_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or after ptr, wrapping.
// The pointer register is owned by the parent so it only moves on an actual issue.
module rr_arbiter #(
    parameter int N_REQ = 2,
    parameter int ID_W  = 1
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  ptr,
    output logic [N_REQ-1:0] grant,
    output logic [ID_W-1:0]  winner,
    output logic             any
);

    int idx;

    always_comb begin
        grant  = '0;
        winner = '0;
        any    = 1'b0;
        idx    = 0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = (int'(ptr) + k) % N_REQ;
            if (!any && req[idx]) begin
                any        = 1'b1;
                grant[idx] = 1'b1;
                winner     = ID_W'(idx);
            end
        end
    end

endmodule

// File: rtl/mult_share_arbiter.sv
// Shares one pipelined multiplier between N_REQ requesters with round-robin issue
// and id-tagged return of each product to the requester that sent the operands.
module mult_share_arbiter
    import mult_arb_pkg::*;
#(
    parameter int N_REQ    = DEF_N_REQ,
    parameter int WIDTH    = DEF_WIDTH,
    parameter int MULT_LAT = DEF_MULT_LAT
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic [N_REQ-1:0]           req_valid,
    output logic [N_REQ-1:0]           req_ready,
    input  logic [N_REQ*WIDTH-1:0]     req_x,
    input  logic [N_REQ*WIDTH-1:0]     req_y,
    output logic [N_REQ-1:0]           rsp_valid,
    output logic [N_REQ*2*WIDTH-1:0]   rsp_z,
    output logic [WIDTH-1:0]           mul_x,
    output logic [WIDTH-1:0]           mul_y,
    input  logic [2*WIDTH-1:0]         mul_z
);

    localparam int ID_W = id_w(N_REQ);

    logic [ID_W-1:0]  rr_ptr;
    logic [N_REQ-1:0] grant;
    logic [ID_W-1:0]  winner;
    logic             any_grant;
    tag_t             issue_tag;
    tag_t             cap_tag;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_rr_arbiter (
        .req    (req_valid),
        .ptr    (rr_ptr),
        .grant  (grant),
        .winner (winner),
        .any    (any_grant)
    );

    // Nothing is accepted while reset is held, even though the pick is combinational.
    assign req_ready = resetn ? grant : '0;

    always_comb begin
        issue_tag       = '0;
        issue_tag.valid = any_grant;
        issue_tag.id    = MAX_ID_W'(winner);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            mul_x  <= '0;
            mul_y  <= '0;
            rr_ptr <= '0;
        end else if (any_grant) begin
            for (int i = 0; i < N_REQ; i++) begin
                if (grant[i]) begin
                    mul_x <= req_x[i*WIDTH +: WIDTH];
                    mul_y <= req_y[i*WIDTH +: WIDTH];
                end
            end
            rr_ptr <= (winner == ID_W'(N_REQ - 1)) ? '0 : winner + 1'b1;
        end
    end

    // Tag pipe mirrors the multiplier depth so the product and its owner line up.
    generate
        if (MULT_LAT == 0) begin : g_no_pipe
            assign cap_tag = issue_tag;
        end else begin : g_pipe
            tag_t tag_pipe [MULT_LAT];

            always_ff @(posedge clk or negedge resetn) begin
                if (!resetn) begin
                    for (int s = 0; s < MULT_LAT; s++) begin
                        tag_pipe[s] <= '0;
                    end
                end else begin
                    tag_pipe[0] <= issue_tag;
                    for (int s = 1; s < MULT_LAT; s++) begin
                        tag_pipe[s] <= tag_pipe[s-1];
                    end
                end
            end

            assign cap_tag = tag_pipe[MULT_LAT-1];
        end
    endgenerate

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rsp_valid <= '0;
            rsp_z     <= '0;
        end else begin
            rsp_valid <= '0;
            for (int i = 0; i < N_REQ; i++) begin
                if (cap_tag.valid && (cap_tag.id == MAX_ID_W'(i))) begin
                    rsp_valid[i]                  <= 1'b1;
                    rsp_z[i*2*WIDTH +: 2*WIDTH]   <= mul_z;
                end
            end
        end
    end

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Self-checking bench: external multiplier model, per-requester scoreboard of products
// with latency tracking, plus directed scenarios for arbitration, corners and reset.
module tb_mult_share_arbiter;

    localparam int N = 2;
    localparam int W = 8;
    localparam int L = 2;

    logic              clk = 1'b0;
    logic              resetn = 1'b1;
    logic [N-1:0]      req_valid = '0;
    logic [N-1:0]      req_ready;
    logic [N*W-1:0]    req_x = '0;
    logic [N*W-1:0]    req_y = '0;
    logic [N-1:0]      rsp_valid;
    logic [N*2*W-1:0]  rsp_z;
    logic [W-1:0]      mul_x;
    logic [W-1:0]      mul_y;
    logic [2*W-1:0]    mul_z = '0;

    int tests_run = 0;
    int tests_failed = 0;
    int cyc = 0;
    int rsp_count = 0;

    logic [2*W-1:0] exp_z [N][$];
    int             exp_c [N][$];

    mult_share_arbiter #(
        .N_REQ    (N),
        .WIDTH    (W),
        .MULT_LAT (L)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_x     (req_x),
        .req_y     (req_y),
        .rsp_valid (rsp_valid),
        .rsp_z     (rsp_z),
        .mul_x     (mul_x),
        .mul_y     (mul_y),
        .mul_z     (mul_z)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Multiplier: product appears one cycle after the registered operands (L-1 stages).
    always @(posedge clk) mul_z <= (2*W)'(mul_x) * (2*W)'(mul_y);

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        logic [2*W-1:0] ez;
        int             ec;
        @(negedge clk);
        if (!resetn) begin
            for (int i = 0; i < N; i++) begin
                exp_z[i].delete();
                exp_c[i].delete();
            end
        end else begin
            tests_run++;
            if (($countones(req_ready) > 1) || ((req_ready & ~req_valid) != '0) ||
                ($countones(rsp_valid) > 1)) begin
                tests_failed++;
                $display("FAIL handshake_rule @%0d: req_ready=%b req_valid=%b rsp_valid=%b, required one-hot-or-zero subset",
                         cyc, req_ready, req_valid, rsp_valid);
            end
            for (int i = 0; i < N; i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    exp_z[i].push_back((2*W)'(req_x[i*W +: W]) * (2*W)'(req_y[i*W +: W]));
                    exp_c[i].push_back(cyc);
                end
            end
            for (int i = 0; i < N; i++) begin
                if (rsp_valid[i]) begin
                    rsp_count++;
                    tests_run++;
                    if (exp_z[i].size() == 0) begin
                        tests_failed++;
                        $display("FAIL rsp_unexpected[%0d] @%0d: got z=%h, required no response", i, cyc, rsp_z[i*2*W +: 2*W]);
                    end else begin
                        ez = exp_z[i].pop_front();
                        ec = exp_c[i].pop_front();
                        if (rsp_z[i*2*W +: 2*W] !== ez || cyc != ec + L + 1) begin
                            tests_failed++;
                            $display("FAIL rsp_product[%0d]: got z=%h at cycle %0d, required z=%h at cycle %0d",
                                     i, rsp_z[i*2*W +: 2*W], cyc, ez, ec + L + 1);
                        end
                    end
                end
            end
        end
    endtask

    task automatic do_reset();
        req_valid = '0;
        next();
        resetn = 1'b0;
        sample();
        next();
        resetn = 1'b1;
    endtask

    task automatic test_reset();
        req_valid = 2'b11;
        #2 resetn = 1'b0;
        #1;
        tests_run++;
        if (req_ready !== 2'b00 || rsp_valid !== 2'b00 || rsp_z !== '0 || mul_x !== '0 || mul_y !== '0) begin
            tests_failed++;
            $display("FAIL reset_state: ready=%b rsp_valid=%b rsp_z=%h mul_x=%h mul_y=%h, required all zero",
                     req_ready, rsp_valid, rsp_z, mul_x, mul_y);
        end
        next();
        sample();
        tests_run++;
        if (req_ready !== 2'b00 || rsp_valid !== 2'b00) begin
            tests_failed++;
            $display("FAIL reset_hold: ready=%b rsp_valid=%b, required 00 00", req_ready, rsp_valid);
        end
        req_valid = '0;
        next();
        resetn = 1'b1;
    endtask

    task automatic test_single();
        int t0;
        req_valid = 2'b01;
        req_x = {8'd0, 8'd3};
        req_y = {8'd0, 8'd5};
        sample();
        t0 = cyc;
        tests_run++;
        if (req_ready !== 2'b01) begin
            tests_failed++;
            $display("FAIL single_grant: req_ready=%b, required 01", req_ready);
        end
        next();
        req_valid = '0;
        for (int k = 1; k <= 6; k++) begin
            sample();
            tests_run++;
            if (rsp_valid !== ((cyc == t0 + 3) ? 2'b01 : 2'b00)) begin
                tests_failed++;
                $display("FAIL single_rsp_valid @+%0d: got %b, required %b", cyc - t0, rsp_valid,
                         (cyc == t0 + 3) ? 2'b01 : 2'b00);
            end
            if (cyc == t0 + 3) begin
                tests_run++;
                if (rsp_z[15:0] !== 16'd15) begin
                    tests_failed++;
                    $display("FAIL single_product: got %h, required 000f", rsp_z[15:0]);
                end
            end
            next();
        end
    endtask

    task automatic test_contention();
        int c0;
        do_reset();
        req_valid = 2'b11;
        req_x = {8'd4, 8'd2};
        req_y = {8'd9, 8'd7};
        c0 = rsp_count;
        for (int k = 0; k < 8; k++) begin
            sample();
            tests_run++;
            if (req_ready !== ((k % 2) ? 2'b10 : 2'b01)) begin
                tests_failed++;
                $display("FAIL contention_grant k=%0d: got %b, required %b", k, req_ready, (k % 2) ? 2'b10 : 2'b01);
            end
            if (k >= 3) begin
                tests_run++;
                if (rsp_valid !== (((k - 3) % 2) ? 2'b10 : 2'b01)) begin
                    tests_failed++;
                    $display("FAIL contention_rsp k=%0d: got %b, required %b", k, rsp_valid, ((k - 3) % 2) ? 2'b10 : 2'b01);
                end
            end
            next();
        end
        req_valid = '0;
        for (int k = 0; k < 6; k++) begin
            sample();
            next();
        end
        tests_run++;
        if (rsp_count - c0 != 8) begin
            tests_failed++;
            $display("FAIL contention_count: got %0d responses, required 8", rsp_count - c0);
        end
    endtask

    task automatic run_seq(input int rq, input logic [7:0] xs[3], input logic [7:0] ys[3],
                           input logic [15:0] zs[3], input string nm);
        int got;
        int first;
        got = 0;
        first = 0;
        for (int j = 0; j < 3; j++) begin
            req_valid = '0;
            req_valid[rq] = 1'b1;
            req_x[rq*W +: W] = xs[j];
            req_y[rq*W +: W] = ys[j];
            sample();
            tests_run++;
            if (req_ready[rq] !== 1'b1) begin
                tests_failed++;
                $display("FAIL %s_grant j=%0d: req_ready=%b, required bit %0d set", nm, j, req_ready, rq);
            end
            next();
        end
        req_valid = '0;
        for (int k = 0; k < 8; k++) begin
            sample();
            if (rsp_valid[rq] && got < 3) begin
                if (got == 0) first = cyc;
                tests_run++;
                if (rsp_z[rq*2*W +: 2*W] !== zs[got] || cyc != first + got) begin
                    tests_failed++;
                    $display("FAIL %s_rsp %0d: got %h at +%0d, required %h at +%0d", nm, got,
                             rsp_z[rq*2*W +: 2*W], cyc - first, zs[got], got);
                end
                got++;
            end
            next();
        end
        tests_run++;
        if (got != 3) begin
            tests_failed++;
            $display("FAIL %s_count: got %0d responses, required 3", nm, got);
        end
    endtask

    task automatic test_corners();
        logic [7:0]  xs[3] = '{8'd255, 8'd0, 8'd1};
        logic [7:0]  ys[3] = '{8'd255, 8'd200, 8'd255};
        logic [15:0] zs[3] = '{16'hFE01, 16'h0000, 16'h00FF};
        run_seq(0, xs, ys, zs, "corners");
    endtask

    task automatic test_back_to_back();
        logic [7:0]  xs[3] = '{8'd1, 8'd2, 8'd3};
        logic [7:0]  ys[3] = '{8'd1, 8'd2, 8'd3};
        logic [15:0] zs[3] = '{16'd1, 16'd4, 16'd9};
        run_seq(1, xs, ys, zs, "b2b");
    endtask

    task automatic test_reset_midflight();
        do_reset();
        req_valid = 2'b11;
        req_x = {8'd6, 8'd5};
        req_y = {8'd7, 8'd3};
        sample();
        next();
        sample();
        next();
        req_valid = '0;
        resetn = 1'b0;
        sample();
        next();
        resetn = 1'b1;
        for (int k = 0; k < 6; k++) begin
            sample();
            tests_run++;
            if (rsp_valid !== 2'b00 || rsp_z !== '0) begin
                tests_failed++;
                $display("FAIL midflight_discard k=%0d: rsp_valid=%b rsp_z=%h, required 00 and 0", k, rsp_valid, rsp_z);
            end
            next();
        end
        req_valid = 2'b11;
        sample();
        tests_run++;
        if (req_ready !== 2'b01) begin
            tests_failed++;
            $display("FAIL midflight_restart: req_ready=%b, required 01", req_ready);
        end
        next();
        req_valid = '0;
        for (int k = 0; k < 6; k++) begin
            sample();
            next();
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 300; k++) begin
            req_valid = N'($urandom_range(0, 3));
            req_x = (N*W)'($urandom);
            req_y = (N*W)'($urandom);
            sample();
            next();
        end
        req_valid = '0;
        for (int k = 0; k < 6; k++) begin
            sample();
            next();
        end
        for (int i = 0; i < N; i++) begin
            tests_run++;
            if (exp_z[i].size() != 0) begin
                tests_failed++;
                $display("FAIL random_drain[%0d]: %0d products outstanding, required 0", i, exp_z[i].size());
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_corners();
        test_back_to_back();
        test_reset_midflight();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
